alu_result_stage: RTL and testbench

- Registered downstream stage for the 8-bit ALU. It captures each ALU result with its operation code and flags into a small FIFO, and presents them to the consumer through a valid/ready handshake.
- It normalises the flags: carry is forced to 0 for non-ADD/SUB ops, and a multiply-overflow flag is added.
- It keeps sticky status: a sticky carry bit and a saturating count of zero results.

---
 rtl/alu_result_stage_if.sv | 25 ++
 rtl/alu_result_stage.sv | 111 +++++++++++
 tb/tb_alu_result_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
// The slave side is the result stage itself.
interface alu_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_result;
  logic        in_carry;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_op, in_result, in_carry, in_zero, out_ready,
    input  in_ready, out_valid, out_op, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_result, in_carry, in_zero, out_ready,
    output in_ready, out_valid, out_op, out_result, out_flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result FIFO stage with flag normalisation and sticky status.
// Head is read combinationally; occupancy counter drives full/empty.
module alu_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_stage_if.slave        bus,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stat,
  output logic                     sticky_carry,
  output logic [CNT_W-1:0]         zero_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] res;
    logic [2:0]  flags;
  } ent_t;

  ent_t             mem_q [DEPTH];
  ent_t             wr_ent;
  ent_t             head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] zc_q, zc_d;
  logic [CNT_W-1:0] zc_base;
  logic             full, empty, push, pop;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  // Normalise flags: carry only for ADD/SUB, overflow only for MUL.
  always_comb begin
    wr_ent          = '0;
    wr_ent.op       = bus.in_op;
    wr_ent.res      = bus.in_result;
    wr_ent.flags[0] = bus.in_zero;
    wr_ent.flags[1] = bus.in_carry && (bus.in_op[2:1] == 2'b00);
    wr_ent.flags[2] = (bus.in_op == 3'b010) &&
                      (bus.in_result[15:8] != 8'h00);
  end

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Sticky status: clear wins over old value, not over a push.
  always_comb begin
    zc_base  = clr_stat ? '0 : zc_q;
    sticky_d = clr_stat ? 1'b0 : sticky_q;
    zc_d     = zc_base;
    if (push) begin
      sticky_d = sticky_d | wr_ent.flags[1];
      if (wr_ent.flags[0] && (zc_base != {CNT_W{1'b1}}))
        zc_d = zc_base + 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      zc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      zc_q     <= zc_d;
    end
  end

  // Storage array; contents are don't-care while not occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_ent;
  end

  // Head presentation, forced to zero when empty.
  always_comb begin
    head = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.out_op     = head.op;
  assign bus.out_result = head.res;
  assign bus.out_flags  = head.flags;
  assign level          = cnt_q;
  assign sticky_carry   = sticky_q;
  assign zero_count     = zc_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed bench for alu_result_stage.
// Expectations come from a queue-based reference model.
module tb_alu_result_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int ZMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] res;
    logic [2:0]  fl;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_stat;
  logic [$clog2(DEPTH):0] level;
  logic sticky_carry;
  logic [CNT_W-1:0] zero_count;

  alu_result_stage_if bus ();

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .level        (level),
    .clr_stat     (clr_stat),
    .sticky_carry (sticky_carry),
    .zero_count   (zero_count)
  );

  always #5 clk = ~clk;

  int   errs = 0;
  int   checks = 0;
  ent_t mq[$];
  int   m_sticky = 0;
  int   m_zc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
    chk({tag, ".out_op"}, 32'(bus.out_op), 32'(h.op));
    chk({tag, ".out_result"}, 32'(bus.out_result), 32'(h.res));
    chk({tag, ".out_flags"}, 32'(bus.out_flags), 32'(h.fl));
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".sticky"}, 32'(sticky_carry), 32'(m_sticky));
    chk({tag, ".zero_count"}, 32'(zero_count), 32'(m_zc));
  endtask

  // One clock: drive inputs, let an edge pass, update model, check.
  task automatic cyc(input string tag, input logic v, input logic [2:0] op,
                     input logic [15:0] r, input logic c, input logic z,
                     input logic rdy, input logic clr);
    bit   do_push, do_pop;
    ent_t e;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_result = r;
    bus.in_carry  = c;
    bus.in_zero   = z;
    bus.out_ready = rdy;
    clr_stat      = clr;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() > 0);
    e.op  = op;
    e.res = r;
    e.fl  = {(op == 3'd2) && (r > 16'd255),
             c && (op == 3'd0 || op == 3'd1), z};
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (clr) begin
      m_sticky = 0;
      m_zc = 0;
    end
    if (do_push) begin
      mq.push_back(e);
      if (e.fl[1]) m_sticky = 1;
      if (z && m_zc < ZMAX) m_zc++;
    end
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_stat = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_result = '0;
    bus.in_carry = 1'b0;
    bus.in_zero = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD with carry.
    cyc("add", 1, 3'd0, 16'h01FE, 1, 0, 0, 0);
    cyc("add_hold", 0, 3'd0, 16'h0, 0, 0, 0, 0);
    cyc("add_pop", 0, 3'd0, 16'h0, 0, 0, 1, 0);

    // MUL overflow, AND with masked carry and zero.
    cyc("mul", 1, 3'd2, 16'h2710, 0, 0, 0, 0);
    cyc("and", 1, 3'd3, 16'h0000, 1, 1, 0, 0);
    cyc("rd1", 0, 3'd0, 16'h0, 0, 0, 1, 0);
    cyc("rd2", 0, 3'd0, 16'h0, 0, 0, 1, 0);

    // Fill, hold off a fifth, then pop-only while full.
    for (int i = 0; i < DEPTH; i++)
      cyc("fill", 1, 3'(i + 4), 16'(16'h100 + i), 0, 0, 0, 0);
    cyc("held", 1, 3'd7, 16'hBEEF, 0, 0, 0, 0);
    cyc("full_pop", 1, 3'd7, 16'hBEEF, 0, 0, 1, 0);
    cyc("accept", 1, 3'd7, 16'hBEEF, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cyc("drain", 0, 3'd0, 16'h0, 0, 0, 1, 0);

    // Continuous stream across pointer wrap.
    for (int i = 0; i < 20; i++)
      cyc("stream", 1, 3'($urandom_range(7)), 16'($urandom), 0, 0, 1, 0);
    cyc("stream_end", 0, 3'd0, 16'h0, 0, 0, 1, 0);

    // Zero-count saturation and clear priority.
    for (int i = 0; i < 5; i++)
      cyc("zsat", 1, 3'd3, 16'h0, 0, 1, 1, 0);
    cyc("clr_push", 1, 3'd3, 16'h0, 0, 1, 1, 1);
    cyc("clr_only", 0, 3'd0, 16'h0, 0, 0, 1, 1);
    cyc("sub_c", 1, 3'd1, 16'h00FF, 1, 0, 1, 0);
    cyc("clr_c", 1, 3'd4, 16'h0001, 1, 0, 1, 1);
    cyc("idle", 0, 3'd0, 16'h0, 0, 0, 1, 0);

    // Asynchronous reset with 3 entries loaded.
    for (int i = 0; i < 3; i++)
      cyc("load", 1, 3'd0, 16'(16'hA0 + i), 1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_sticky = 0;
    m_zc = 0;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 0, 3'd0, 16'h0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      r = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      cyc("rand", 1'($urandom_range(1)), 3'($urandom_range(7)), r,
          1'($urandom_range(1)), r == 16'h0,
          1'($urandom_range(1)), $urandom_range(15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
